// File: rtl/drive_pkg.sv
// rtl/drive_pkg.sv - shared types and helpers for the dual H-bridge motor drive
//
// Purpose: direction command encoding, per-channel polarity and state types,
// common widths, and the duty ramp helper used by each channel.
// Ports: none (package).

package drive_pkg;

  localparam int CNT_W   = 14;  // holds PWM_PERIOD up to 16383
  localparam int DEAD_W  = 16;  // holds DEADTIME up to 65535
  localparam int SPEED_W = 21;

  typedef enum logic [1:0] {
    DIR_STRAIGHT = 2'd0,
    DIR_LEFT     = 2'd1,
    DIR_RIGHT    = 2'd2,
    DIR_STOP     = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    POL_OFF = 2'd0,
    POL_FWD = 2'd1,
    POL_REV = 2'd2
  } pol_e;

  typedef enum logic [1:0] {
    CH_OFF  = 2'd0,
    CH_RUN  = 2'd1,
    CH_DEAD = 2'd2
  } ch_state_e;

  // Move cur toward tgt by at most step, landing exactly on tgt when close.
  function automatic logic [CNT_W-1:0] ramp_toward(
    input logic [CNT_W-1:0] cur,
    input logic [CNT_W-1:0] tgt,
    input logic [CNT_W-1:0] step
  );
    logic [CNT_W-1:0] r;
    r = tgt;
    if (cur < tgt) begin
      if ((tgt - cur) > step) r = cur + step;
    end else if (cur > tgt) begin
      if ((cur - tgt) > step) r = cur - step;
    end
    return r;
  endfunction

endpackage

// File: rtl/hbridge_channel.sv
// rtl/hbridge_channel.sv - one H-bridge channel: OFF/RUN/DEAD state machine with ramped PWM
//
// Purpose: tracks the commanded polarity for one motor, ramps its duty toward
// the target once per PWM period, and inserts a dead interval with both legs
// off whenever the polarity reverses.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   tick           one-cycle strobe at the last count of each PWM period
//   cnt_next       value the shared PWM counter takes on the next edge
//   cmd            polarity requested for this motor (OFF/FWD/REV)
//   target         saturated target duty in clk cycles
//   in1, in2, pwm  registered bridge leg controls and enable PWM
//   dead_next      high when the channel will be in DEAD after this edge

module hbridge_channel
  import drive_pkg::*;
#(
  parameter int unsigned DEADTIME  = 500,
  parameter int unsigned RAMP_STEP = 50
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic [CNT_W-1:0] cnt_next,
  input  pol_e             cmd,
  input  logic [CNT_W-1:0] target,
  output logic             in1,
  output logic             in2,
  output logic             pwm,
  output logic             dead_next
);

  // A step wider than the counter can never bind, so clamp it to fit.
  localparam int unsigned     STEP_SAT  = (RAMP_STEP > 16383) ? 16383 : RAMP_STEP;
  localparam logic [CNT_W-1:0]  STEP      = CNT_W'(STEP_SAT);
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEADTIME);

  ch_state_e         state, state_n;
  pol_e              pol, pol_n;
  logic [CNT_W-1:0]  duty, duty_n;
  logic [DEAD_W-1:0] dead_cnt, dead_cnt_n;
  logic [CNT_W-1:0]  start_duty;

  assign start_duty = (target < STEP) ? target : STEP;

  always_comb begin
    state_n    = state;
    pol_n      = pol;
    duty_n     = duty;
    // The dead counter runs every clock, independent of the period tick.
    dead_cnt_n = ((state == CH_DEAD) && (dead_cnt != '0)) ? dead_cnt - DEAD_W'(1) : dead_cnt;
    if (tick) begin
      case (state)
        CH_OFF: begin
          if (cmd != POL_OFF) begin
            state_n = CH_RUN;
            pol_n   = cmd;
            duty_n  = start_duty;
          end
        end
        CH_RUN: begin
          if (cmd == POL_OFF) begin
            state_n = CH_OFF;
            pol_n   = POL_OFF;
            duty_n  = '0;
          end else if (cmd != pol) begin
            state_n    = CH_DEAD;
            duty_n     = '0;
            dead_cnt_n = DEAD_LOAD;
          end else begin
            duty_n = ramp_toward(duty, target, STEP);
          end
        end
        CH_DEAD: begin
          // Commands seen during the dead interval are ignored; only the one
          // present at the exit tick decides where the channel goes.
          if (dead_cnt == '0) begin
            if (cmd == POL_OFF) begin
              state_n = CH_OFF;
              pol_n   = POL_OFF;
              duty_n  = '0;
            end else begin
              state_n = CH_RUN;
              pol_n   = cmd;
              duty_n  = start_duty;
            end
          end
        end
        default: begin
          state_n = CH_OFF;
          pol_n   = POL_OFF;
          duty_n  = '0;
        end
      endcase
    end
  end

  assign dead_next = (state_n == CH_DEAD);

  // Outputs are computed from next-state values so that a new duty or state
  // appears exactly when the counter wraps to 0, with no mid-period change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= CH_OFF;
      pol      <= POL_OFF;
      duty     <= '0;
      dead_cnt <= '0;
      in1      <= 1'b0;
      in2      <= 1'b0;
      pwm      <= 1'b0;
    end else begin
      state    <= state_n;
      pol      <= pol_n;
      duty     <= duty_n;
      dead_cnt <= dead_cnt_n;
      in1      <= (state_n == CH_RUN) && (pol_n == POL_FWD);
      in2      <= (state_n == CH_RUN) && (pol_n == POL_REV);
      pwm      <= (state_n == CH_RUN) && (cnt_next < duty_n);
    end
  end

endmodule

// File: rtl/motor_drive.sv
// rtl/motor_drive.sv - dual H-bridge steering drive with shared PWM period
//
// Purpose: free-running PWM counter, registered command inputs, steering to
// per-motor polarity mapping and duty saturation; two hbridge_channel
// instances drive the left and right motors.
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   enable                           0 forces both channels OFF
//   direction                        0 STRAIGHT, 1 LEFT, 2 RIGHT, 3 STOP
//   speed                            requested duty in clk cycles
//   left_in1, left_in2, left_pwm     left bridge controls
//   right_in1, right_in2, right_pwm  right bridge controls
//   busy                             high while either channel is in DEAD

module motor_drive
  import drive_pkg::*;
#(
  parameter int unsigned PWM_PERIOD = 10000,
  parameter int unsigned DEADTIME   = 500,
  parameter int unsigned RAMP_STEP  = 50
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [1:0]         direction,
  input  logic [SPEED_W-1:0] speed,
  output logic               left_in1,
  output logic               left_in2,
  output logic               left_pwm,
  output logic               right_in1,
  output logic               right_in2,
  output logic               right_pwm,
  output logic               busy
);

  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               tick;
  logic               enable_r;
  dir_e               dir_r;
  logic [SPEED_W-1:0] speed_r;
  pol_e               cmd_l, cmd_r;
  logic [CNT_W-1:0]   target;
  logic               dead_l, dead_r;

  assign tick     = (cnt == CNT_W'(PWM_PERIOD - 1));
  assign cnt_next = tick ? '0 : cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      enable_r <= 1'b0;
      dir_r    <= DIR_STOP;
      speed_r  <= '0;
      busy     <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      enable_r <= enable;
      dir_r    <= dir_e'(direction);
      speed_r  <= speed;
      busy     <= dead_l | dead_r;
    end
  end

  assign target = (speed_r > SPEED_W'(PWM_PERIOD)) ? CNT_W'(PWM_PERIOD) : speed_r[CNT_W-1:0];

  // Steering: turning reverses the motor on the inside of the turn.
  always_comb begin
    cmd_l = POL_OFF;
    cmd_r = POL_OFF;
    if (enable_r) begin
      case (dir_r)
        DIR_STRAIGHT: begin cmd_l = POL_FWD; cmd_r = POL_FWD; end
        DIR_LEFT:     begin cmd_l = POL_REV; cmd_r = POL_FWD; end
        DIR_RIGHT:    begin cmd_l = POL_FWD; cmd_r = POL_REV; end
        default:      begin cmd_l = POL_OFF; cmd_r = POL_OFF; end
      endcase
    end
  end

  hbridge_channel #(
    .DEADTIME  (DEADTIME),
    .RAMP_STEP (RAMP_STEP)
  ) u_left (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .cnt_next  (cnt_next),
    .cmd       (cmd_l),
    .target    (target),
    .in1       (left_in1),
    .in2       (left_in2),
    .pwm       (left_pwm),
    .dead_next (dead_l)
  );

  hbridge_channel #(
    .DEADTIME  (DEADTIME),
    .RAMP_STEP (RAMP_STEP)
  ) u_right (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .cnt_next  (cnt_next),
    .cmd       (cmd_r),
    .target    (target),
    .in1       (right_in1),
    .in2       (right_in2),
    .pwm       (right_pwm),
    .dead_next (dead_r)
  );

endmodule

// File: tb/tb_motor_drive.sv
// tb/tb_motor_drive.sv - directed self-checking bench for motor_drive

module tb_motor_drive;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [1:0]  direction;
  logic [20:0] speed;
  logic        left_in1, left_in2, left_pwm;
  logic        right_in1, right_in2, right_pwm;
  logic        busy;

  int checks = 0;
  int errors = 0;

  motor_drive #(
    .PWM_PERIOD (100),
    .DEADTIME   (10),
    .RAMP_STEP  (20)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .direction (direction),
    .speed     (speed),
    .left_in1  (left_in1),
    .left_in2  (left_in2),
    .left_pwm  (left_pwm),
    .right_in1 (right_in1),
    .right_in2 (right_in2),
    .right_pwm (right_pwm),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".l_in1"}, int'(left_in1), 0);
    check({tag, ".l_in2"}, int'(left_in2), 0);
    check({tag, ".l_pwm"}, int'(left_pwm), 0);
    check({tag, ".r_in1"}, int'(right_in1), 0);
    check({tag, ".r_in2"}, int'(right_in2), 0);
    check({tag, ".r_pwm"}, int'(right_pwm), 0);
    check({tag, ".busy"}, int'(busy), 0);
  endtask

  // Runs one full PWM period starting at a negedge where the DUT counter is 0,
  // counting high cycles of every output. tmode 1/2 toggle LEFT/RIGHT every
  // 3 cycles (mode 1 leaves RIGHT at the tick, mode 2 leaves LEFT).
  task automatic period_check(input string tag, input int tmode,
                              input int e_lp, input int e_l1, input int e_l2,
                              input int e_rp, input int e_r1, input int e_r2,
                              input int e_bz);
    int lp = 0, l1 = 0, l2 = 0, rp = 0, r1 = 0, r2 = 0, bz = 0;
    for (int i = 0; i < 100; i++) begin
      if (tmode == 1)      direction = (((i / 3) % 2) == 0) ? 2'd2 : 2'd1;
      else if (tmode == 2) direction = (((i / 3) % 2) == 1) ? 2'd2 : 2'd1;
      lp += int'(left_pwm);  l1 += int'(left_in1);  l2 += int'(left_in2);
      rp += int'(right_pwm); r1 += int'(right_in1); r2 += int'(right_in2);
      bz += int'(busy);
      @(negedge clk);
    end
    check({tag, ".l_pwm"}, lp, e_lp);
    check({tag, ".l_in1"}, l1, e_l1);
    check({tag, ".l_in2"}, l2, e_l2);
    check({tag, ".r_pwm"}, rp, e_rp);
    check({tag, ".r_in1"}, r1, e_r1);
    check({tag, ".r_in2"}, r2, e_r2);
    check({tag, ".busy"}, bz, e_bz);
  endtask

  // Both legs of a bridge must never be driven together.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      checks++;
      assert (!(left_in1 && left_in2) && !(right_in1 && right_in2)) else begin
        errors++;
        $error("FAIL leg_overlap observed l=%b%b r=%b%b expected no 11",
               left_in1, left_in2, right_in1, right_in2);
      end
    end
  end

  initial begin
    int ramp[5];
    ramp = '{20, 40, 60, 70, 70};

    reset_n   = 1'b0;
    enable    = 1'b0;
    direction = 2'd3;
    speed     = 21'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");

    // Ramp to 70 going straight
    enable    = 1'b1;
    direction = 2'd0;
    speed     = 21'd70;
    reset_n   = 1'b1;
    period_check("idle", 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++)
      period_check($sformatf("ramp%0d", k), 0, ramp[k], 100, 0, ramp[k], 100, 0, 0);

    // Saturation at the period length
    speed = 21'd250;
    period_check("sat0", 0, 70, 100, 0, 70, 100, 0, 0);
    period_check("sat1", 0, 90, 100, 0, 90, 100, 0, 0);
    period_check("sat2", 0, 100, 100, 0, 100, 100, 0, 0);
    period_check("sat3", 0, 100, 100, 0, 100, 100, 0, 0);

    // Ramp down to 60
    speed = 21'd60;
    period_check("down0", 0, 100, 100, 0, 100, 100, 0, 0);
    period_check("down1", 0, 80, 100, 0, 80, 100, 0, 0);
    period_check("down2", 0, 60, 100, 0, 60, 100, 0, 0);

    // LEFT: left reverses through DEAD, right unaffected
    direction = 2'd1;
    period_check("left0", 0, 60, 100, 0, 60, 100, 0, 0);
    period_check("left_dead", 0, 0, 0, 0, 60, 100, 0, 100);
    period_check("left_rev", 0, 20, 0, 100, 60, 100, 0, 0);

    // Back to STRAIGHT at 80
    direction = 2'd0;
    speed     = 21'd80;
    period_check("str0", 0, 40, 0, 100, 60, 100, 0, 0);
    period_check("str_dead", 0, 0, 0, 0, 80, 100, 0, 100);
    period_check("str_fwd", 0, 20, 100, 0, 80, 100, 0, 0);

    // STOP coasts immediately at the next period
    direction = 2'd3;
    period_check("stop0", 0, 40, 100, 0, 80, 100, 0, 0);
    period_check("stop1", 0, 0, 0, 0, 0, 0, 0, 0);

    // enable=0 does the same
    direction = 2'd0;
    period_check("en0", 0, 0, 0, 0, 0, 0, 0, 0);
    period_check("en1", 0, 20, 100, 0, 20, 100, 0, 0);
    enable = 1'b0;
    period_check("dis0", 0, 40, 100, 0, 40, 100, 0, 0);
    period_check("dis1", 0, 0, 0, 0, 0, 0, 0, 0);

    // Rapid LEFT/RIGHT toggling
    enable    = 1'b1;
    direction = 2'd1;
    speed     = 21'd50;
    period_check("tog_idle", 0, 0, 0, 0, 0, 0, 0, 0);
    period_check("tog_run", 0, 20, 0, 100, 20, 100, 0, 0);
    period_check("tog_a", 1, 40, 0, 100, 40, 100, 0, 0);
    period_check("tog_dead", 2, 0, 0, 0, 0, 0, 0, 100);
    direction = 2'd1;
    period_check("tog_exit", 0, 20, 0, 100, 20, 100, 0, 0);

    // Reset in the middle of a dead interval
    direction = 2'd2;
    period_check("pre_rst", 0, 40, 0, 100, 40, 100, 0, 0);
    repeat (50) @(negedge clk);
    check("mid_dead.busy", int'(busy), 1);
    check("mid_dead.l_in1", int'(left_in1), 0);
    check("mid_dead.r_in2", int'(right_in2), 0);
    reset_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    direction = 2'd0;
    speed     = 21'd40;
    repeat (2) @(negedge clk);
    check_all_zero("rst_hold");
    reset_n = 1'b1;
    period_check("rst_idle", 0, 0, 0, 0, 0, 0, 0, 0);
    period_check("rst_r0", 0, 20, 100, 0, 20, 100, 0, 0);
    period_check("rst_r1", 0, 40, 100, 0, 40, 100, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
